cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common-data-bus arbiter between the result producers (ALU1, ALU2, LSB load path) and the consumers of broadcast results (reservation station, LSB, ROB). Each producer writes into a private FIFO. Each cycle, a round-robin scheduler grants up to two FIFO heads onto two broadcast buses. This decouples producer completion from bus availability, and guarantees that every produced result is broadcast exactly once unless a mispredict flush discards it.

## Interface
- ROB_WIDTH, 4, width of the ROB tag carried with each result
- FIFO_WIDTH, 1, log2 of per-source FIFO depth (depth = 2**FIFO_WIDTH)

- clk_in  input  1  system clock; the only clock
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  global ready; state frozen when low
- clear_signal  input  1  mispredict flush, effective only when rdy_in=1
- done_alu_1 / done_alu_2 / done_lsb  input  1  push request per source (sources 0/1/2)
- value_alu_1 / value_alu_2 / value_lsb  input  32  result value
- tag_alu_1 / tag_alu_2 / tag_lsb  input  ROB_WIDTH  result ROB tag
- full_alu_1 / full_alu_2 / full_lsb  output  1  FIFO holds DEPTH entries; producer must not push
- cdb_valid_1 / cdb_valid_2  output  1  broadcast bus 1/2 carries a result this cycle
- cdb_value_1 / cdb_value_2  output  32  broadcast value; 0 when the matching valid is 0
- cdb_tag_1 / cdb_tag_2  output  ROB_WIDTH  broadcast tag; 0 when the matching valid is 0
- overflow  output  1  sticky: a push was attempted while the source FIFO was full

## Operation
- State per source: circular FIFO with head pointer, tail pointer and count (FIFO_WIDTH+1 bits). Shared state: rr_ptr in {0,1,2}; overflow flag.
- Eligibility: a source is eligible when count>0, or when bypass applies (see Configuration).
- Grant:
  - Scan sources circularly starting at rr_ptr.
  - The first eligible source drives bus 1. The next eligible source drives bus 2.
  - A source gets at most one grant per cycle.
  - The bus outputs are combinational from FIFO heads or the bypass path.
- rr_ptr update: on a cycle with at least one grant, rr_ptr becomes (last granted source + 1) mod 3. With no grant, rr_ptr is unchanged.
- Pop: each granted FIFO head is dequeued at the clock edge.
- Push: `done_x` with full_x=0 enqueues at the tail.
  - Push and pop on the same source in the same cycle leaves count unchanged.
  - full_x is computed from the registered count only. A push while full is dropped, even if the same cycle pops; it sets overflow.
- Wrap-around: pointers are FIFO_WIDTH bits and wrap naturally. The count distinguishes full from empty.
- Flush (rdy_in & clear_signal):
  - All counts, pointers and rr_ptr clear to 0.
  - Pushes that cycle are discarded.
  - cdb_valid_1/2 are forced to 0 that cycle.
  - overflow is retained.
- rdy_in=0: no push, pop, pointer or rr_ptr change. cdb_valid_1/2 are forced to 0. full_x still reflects the stored count.
- Reset (rst_in=1, regardless of rdy_in): FIFOs empty, rr_ptr=0, overflow=0. Outputs the cycle after: all cdb_* = 0, all full_x = 0, overflow = 0. Reset mid-operation discards all queued results.

## Timing
- Without bypass: a push at edge N appears on a bus during cycle N+1 at the earliest, and is popped at edge N+1. Minimum latency is 1 cycle.
- With bypass: minimum latency is 0 cycles, i.e. broadcast in the same cycle as `done_x`.
- Throughput: 2 results per cycle total; 1 per source per cycle.
- Queuing bound: with three sources pushing every cycle, one source per cycle is deferred. Round-robin guarantees each non-empty source a grant within 2 cycles.
- Ordering: results from one source are broadcast in push order. There is no ordering guarantee across sources.

## Configuration
- Macro: CDB_BYPASS_EN.
- Defined:
  - A source whose FIFO is empty and which asserts `done_x` is eligible that cycle. Its input value and tag drive the granted bus directly.
  - If granted, the entry is not written into the FIFO. If not granted, it is enqueued normally.
- Undefined: every result passes through its FIFO. Eligibility depends on count>0 only.

## Test plan
- Reset then idle:
  - Stimulus: rst_in=1 for 2 cycles, then all done_x=0.
  - Response: cdb_valid_1/2=0, cdb_value/tag=0, full_x=0, overflow=0 for 10 cycles.
- Single result:
  - Stimulus: done_alu_1 with value 0xDEADBEEF, tag 5.
  - Response without bypass: cdb_valid_1=1, value 0xDEADBEEF, tag 5 exactly one cycle later; cdb_valid_2=0.
  - Response with CDB_BYPASS_EN: the same appears in the same cycle.
- Three-way contention:
  - Stimulus: all three sources push once in the same cycle, tags 1/2/3, rr_ptr=0.
  - Response: next cycle tags 1 and 2 on buses 1/2; the cycle after, tag 3 on bus 1; rr_ptr then equals 0.
- Full and overflow (FIFO_WIDTH=1):
  - Stimulus: done_lsb for 3 consecutive cycles while rdy_in is held 0 after the first 2 pushes.
  - Response: full_lsb=1 after 2 entries; the third push is dropped; overflow=1 and stays 1 until reset.
- Flush:
  - Stimulus: queue 2 entries in each FIFO, then assert clear_signal with rdy_in=1 for 1 cycle.
  - Response: cdb_valid_1/2=0 that cycle and after; full_x=0; no flushed tag is ever broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: three per-source result FIFOs and a round-robin scheduler driving two broadcast buses.
// Optional same-cycle bypass of empty FIFOs is enabled by defining CDB_BYPASS_EN.
module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_WIDTH = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,

    input  logic                 done_alu_1,
    input  logic [31:0]          value_alu_1,
    input  logic [ROB_WIDTH-1:0] tag_alu_1,
    input  logic                 done_alu_2,
    input  logic [31:0]          value_alu_2,
    input  logic [ROB_WIDTH-1:0] tag_alu_2,
    input  logic                 done_lsb,
    input  logic [31:0]          value_lsb,
    input  logic [ROB_WIDTH-1:0] tag_lsb,

    output logic                 full_alu_1,
    output logic                 full_alu_2,
    output logic                 full_lsb,

    output logic                 cdb_valid_1,
    output logic [31:0]          cdb_value_1,
    output logic [ROB_WIDTH-1:0] cdb_tag_1,
    output logic                 cdb_valid_2,
    output logic [31:0]          cdb_value_2,
    output logic [ROB_WIDTH-1:0] cdb_tag_2,

    output logic                 overflow
);

    localparam int DEPTH = 1 << FIFO_WIDTH;
    localparam int NSRC  = 3;

    typedef logic [FIFO_WIDTH-1:0] ptr_t;
    typedef logic [FIFO_WIDTH:0]   cnt_t;

    typedef struct packed {
        logic [31:0]          value;
        logic [ROB_WIDTH-1:0] tag;
    } entry_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam ptr_t PTR_ONE  = ptr_t'(1);

    // Circular add modulo the number of sources (0..2).
    function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    logic [NSRC-1:0] done_w;
    entry_t          in_w [NSRC];

    assign done_w  = {done_lsb, done_alu_2, done_alu_1};
    assign in_w[0] = {value_alu_1, tag_alu_1};
    assign in_w[1] = {value_alu_2, tag_alu_2};
    assign in_w[2] = {value_lsb,   tag_lsb};

    entry_t     mem_q   [NSRC][DEPTH];
    ptr_t       head_q  [NSRC];
    ptr_t       tail_q  [NSRC];
    cnt_t       count_q [NSRC];
    logic [1:0] rr_q;
    logic [1:0] rr_d;
    logic       overflow_q;

    logic            active_w;
    logic [NSRC-1:0] full_w;
    logic [NSRC-1:0] nonempty_w;
    logic [NSRC-1:0] elig_w;
    logic [NSRC-1:0] granted_w;
    logic [NSRC-1:0] push_w;
    logic [NSRC-1:0] pop_w;
    entry_t          head_w [NSRC];

    logic       g1_vld;
    logic [1:0] g1_src;
    logic       g2_vld;
    logic [1:0] g2_src;
    logic [1:0] scan_src;
    entry_t     bus1_w;
    entry_t     bus2_w;

    // Buses only broadcast while the pipeline runs and no flush is in progress.
    assign active_w = rdy_in & ~clear_signal;

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            full_w[s]     = (count_q[s] == CNT_FULL);
            nonempty_w[s] = (count_q[s] != '0);
`ifdef CDB_BYPASS_EN
            elig_w[s] = nonempty_w[s] | done_w[s];
            head_w[s] = nonempty_w[s] ? mem_q[s][head_q[s]] : in_w[s];
`else
            elig_w[s] = nonempty_w[s];
            head_w[s] = mem_q[s][head_q[s]];
`endif
        end
    end

    // NOTE: every signal gets a default before the scan so no path leaves it unassigned (no latch).
    always_comb begin
        g1_vld   = 1'b0;
        g1_src   = 2'd0;
        g2_vld   = 1'b0;
        g2_src   = 2'd0;
        scan_src = 2'd0;
        for (int k = 0; k < NSRC; k++) begin
            scan_src = wrap_add(rr_q, 2'(k));
            if (elig_w[scan_src]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_src = scan_src;
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2_src = scan_src;
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            granted_w[s] = (g1_vld && (g1_src == 2'(s))) || (g2_vld && (g2_src == 2'(s)));
            pop_w[s]     = active_w & granted_w[s] & nonempty_w[s];
`ifdef CDB_BYPASS_EN
            // A bypassed result was broadcast straight from the inputs and must not also be queued.
            push_w[s] = active_w & done_w[s] & ~full_w[s] & ~(granted_w[s] & ~nonempty_w[s]);
`else
            push_w[s] = active_w & done_w[s] & ~full_w[s];
`endif
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (active_w && g1_vld) begin
            rr_d = wrap_add(g2_vld ? g2_src : g1_src, 2'd1);
        end
    end

    always_comb begin
        bus1_w = head_w[g1_src];
        bus2_w = head_w[g2_src];
    end

    assign cdb_valid_1 = active_w & g1_vld;
    assign cdb_valid_2 = active_w & g2_vld;
    assign cdb_value_1 = cdb_valid_1 ? bus1_w.value : '0;
    assign cdb_tag_1   = cdb_valid_1 ? bus1_w.tag   : '0;
    assign cdb_value_2 = cdb_valid_2 ? bus2_w.value : '0;
    assign cdb_tag_2   = cdb_valid_2 ? bus2_w.tag   : '0;

    assign full_alu_1 = full_w[0];
    assign full_alu_2 = full_w[1];
    assign full_lsb   = full_w[2];
    assign overflow   = overflow_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < NSRC; s++) begin
                head_q[s]  <= '0;
                tail_q[s]  <= '0;
                count_q[s] <= '0;
            end
            rr_q       <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (|(done_w & full_w)) begin
                overflow_q <= 1'b1;
            end
            if (rdy_in && clear_signal) begin
                for (int s = 0; s < NSRC; s++) begin
                    head_q[s]  <= '0;
                    tail_q[s]  <= '0;
                    count_q[s] <= '0;
                end
                rr_q <= 2'd0;
            end else begin
                rr_q <= rr_d;
                for (int s = 0; s < NSRC; s++) begin
                    if (push_w[s]) begin
                        tail_q[s] <= tail_q[s] + PTR_ONE;
                    end
                    if (pop_w[s]) begin
                        head_q[s] <= head_q[s] + PTR_ONE;
                    end
                    unique case ({push_w[s], pop_w[s]})
                        2'b10:   count_q[s] <= count_q[s] + CNT_ONE;
                        2'b01:   count_q[s] <= count_q[s] - CNT_ONE;
                        default: count_q[s] <= count_q[s];
                    endcase
                end
            end
        end
    end

    // NOTE: entry storage has no reset; the counts alone define which slots hold live data.
    always_ff @(posedge clk_in) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push_w[s]) begin
                mem_q[s][tail_q[s]] <= in_w[s];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Honours CDB_BYPASS_EN the same way as the design.
module tb_cdb_arbiter;

    localparam int RW    = 4;
    localparam int FW    = 1;
    localparam int DEPTH = 1 << FW;
    localparam int DW    = 32 + RW;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rdy;
    logic          clr;
    logic          done [3];
    logic [31:0]   val  [3];
    logic [RW-1:0] tag  [3];

    logic          full_alu_1, full_alu_2, full_lsb;
    logic          cdb_valid_1, cdb_valid_2;
    logic [31:0]   cdb_value_1, cdb_value_2;
    logic [RW-1:0] cdb_tag_1, cdb_tag_2;
    logic          overflow;

    cdb_arbiter #(.ROB_WIDTH(RW), .FIFO_WIDTH(FW)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .rdy_in      (rdy),
        .clear_signal(clr),
        .done_alu_1  (done[0]),
        .value_alu_1 (val[0]),
        .tag_alu_1   (tag[0]),
        .done_alu_2  (done[1]),
        .value_alu_2 (val[1]),
        .tag_alu_2   (tag[1]),
        .done_lsb    (done[2]),
        .value_lsb   (val[2]),
        .tag_lsb     (tag[2]),
        .full_alu_1  (full_alu_1),
        .full_alu_2  (full_alu_2),
        .full_lsb    (full_lsb),
        .cdb_valid_1 (cdb_valid_1),
        .cdb_value_1 (cdb_value_1),
        .cdb_tag_1   (cdb_tag_1),
        .cdb_valid_2 (cdb_valid_2),
        .cdb_value_2 (cdb_value_2),
        .cdb_tag_2   (cdb_tag_2),
        .overflow    (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue of {value,tag} per source plus the round-robin start index.
    logic [DW-1:0] q [3][$];
    int            rr  = 0;
    bit            ovf = 1'b0;
    int            g1, g2;
    int            sz    [3];
    bit            mfull [3];
    bit            elig  [3];

    function automatic logic [DW-1:0] entry(input int s);
        return (sz[s] > 0) ? q[s][0] : {val[s], tag[s]};
    endfunction

    // Evaluate the model for the current inputs and compare every DUT output.
    task automatic settle();
        bit            act;
        logic [DW-1:0] e1, e2;
        #1;
        act = rdy && !clr;
        g1  = -1;
        g2  = -1;
        for (int s = 0; s < 3; s++) begin
            sz[s]    = q[s].size();
            mfull[s] = (sz[s] == DEPTH);
            elig[s]  = (sz[s] > 0) || (BYP && done[s]);
        end
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (rr + k) % 3;
            if (elig[s]) begin
                if (g1 < 0)      g1 = s;
                else if (g2 < 0) g2 = s;
            end
        end
        e1 = (act && g1 >= 0) ? entry(g1) : '0;
        e2 = (act && g2 >= 0) ? entry(g2) : '0;
        if (!rst) begin
            check("cdb_valid_1", cdb_valid_1, act && g1 >= 0);
            check("bus1_data",   {cdb_value_1, cdb_tag_1}, e1);
            check("cdb_valid_2", cdb_valid_2, act && g2 >= 0);
            check("bus2_data",   {cdb_value_2, cdb_tag_2}, e2);
            check("full_alu_1",  full_alu_1, mfull[0]);
            check("full_alu_2",  full_alu_2, mfull[1]);
            check("full_lsb",    full_lsb,   mfull[2]);
            check("overflow",    overflow,   ovf);
        end
    endtask

    // Apply the clock edge to the model, then return to the falling edge for the next drive.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            for (int s = 0; s < 3; s++) q[s].delete();
            rr  = 0;
            ovf = 1'b0;
        end else begin
            for (int s = 0; s < 3; s++) if (done[s] && mfull[s]) ovf = 1'b1;
            if (rdy && clr) begin
                for (int s = 0; s < 3; s++) q[s].delete();
                rr = 0;
            end else if (rdy) begin
                for (int s = 0; s < 3; s++) begin
                    bit gr;
                    gr = (s == g1) || (s == g2);
                    if (gr && sz[s] > 0) void'(q[s].pop_front());
                    if (done[s] && !mfull[s] && !(gr && sz[s] == 0)) q[s].push_back({val[s], tag[s]});
                end
                if (g1 >= 0) rr = ((g2 >= 0 ? g2 : g1) + 1) % 3;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic set_idle();
        rst = 1'b0;
        rdy = 1'b1;
        clr = 1'b0;
        for (int s = 0; s < 3; s++) begin
            done[s] = 1'b0;
            val[s]  = '0;
            tag[s]  = '0;
        end
    endtask

    task automatic push(input int s, input logic [31:0] v, input logic [RW-1:0] t);
        done[s] = 1'b1;
        val[s]  = v;
        tag[s]  = t;
    endtask

    task automatic flush();
        set_idle();
        clr = 1'b1;
        cyc();
        set_idle();
    endtask

    // All three sources push once with rr_ptr at 0; the first two go out together, the third next cycle.
    task automatic three_way(input logic [RW-1:0] base);
        set_idle();
        push(0, 32'h1000 + 32'(base), base);
        push(1, 32'h2000 + 32'(base), base + 4'd1);
        push(2, 32'h3000 + 32'(base), base + 4'd2);
`ifndef CDB_BYPASS_EN
        cyc();
        set_idle();
`endif
        settle();
        check("three_way_v1",  cdb_valid_1, 1'b1);
        check("three_way_t1",  cdb_tag_1,   base);
        check("three_way_v2",  cdb_valid_2, 1'b1);
        check("three_way_t2",  cdb_tag_2,   base + 4'd1);
        advance();
        set_idle();
        settle();
        check("three_way_t3",  cdb_tag_1,   base + 4'd2);
        check("three_way_v3",  cdb_valid_1, 1'b1);
        check("three_way_v2b", cdb_valid_2, 1'b0);
        advance();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            settle();
            check("idle_valid_1", cdb_valid_1, 1'b0);
            check("idle_valid_2", cdb_valid_2, 1'b0);
            check("idle_bus1",    {cdb_value_1, cdb_tag_1}, '0);
            check("idle_full",    {full_alu_1, full_alu_2, full_lsb}, 3'b000);
            check("idle_overflow", overflow, 1'b0);
            advance();
        end

        // Single result from ALU1.
        push(0, 32'hDEADBEEF, 4'd5);
`ifndef CDB_BYPASS_EN
        cyc();
        set_idle();
`endif
        settle();
        check("single_valid_1", cdb_valid_1, 1'b1);
        check("single_value",   cdb_value_1, 32'hDEADBEEF);
        check("single_tag",     cdb_tag_1,   4'd5);
        check("single_valid_2", cdb_valid_2, 1'b0);
        advance();
        set_idle();
        for (int i = 0; i < 3; i++) cyc();

        // Contention; the second round also shows rr_ptr came back to 0.
        flush();
        three_way(4'd1);
        three_way(4'd4);

        // Fill the LSB FIFO, then attempt a push while stalled and full.
        flush();
        push(0, 32'hA0, 4'd1); push(1, 32'hA1, 4'd2); push(2, 32'hA2, 4'd3);
        cyc();
        push(0, 32'hB0, 4'd4); push(1, 32'hB1, 4'd5); push(2, 32'hB2, 4'd6);
        cyc();
        set_idle();
        rdy = 1'b0;
        push(2, 32'hC2, 4'd7);
        settle();
`ifndef CDB_BYPASS_EN
        check("stall_full_lsb",     full_lsb, 1'b1);
        check("stall_overflow_pre", overflow, 1'b0);
`endif
        check("stall_valid_1", cdb_valid_1, 1'b0);
        advance();
        done[2] = 1'b0;
        settle();
`ifndef CDB_BYPASS_EN
        check("overflow_set",    overflow, 1'b1);
        check("still_full_lsb",  full_lsb, 1'b1);
`endif
        advance();
        set_idle();
        for (int i = 0; i < 4; i++) cyc();
        settle();
`ifndef CDB_BYPASS_EN
        check("overflow_sticky", overflow, 1'b1);
`endif
        check("drained_full_lsb", full_lsb, 1'b0);
        advance();

        // Flush with entries queued in every FIFO.
        for (int c = 0; c < 3; c++) begin
            set_idle();
            push(0, 32'hF00 + 32'(c), 4'd12);
            push(1, 32'hF10 + 32'(c), 4'd13);
            if (c < 2) push(2, 32'hF20 + 32'(c), 4'd14);
            cyc();
        end
        set_idle();
        clr = 1'b1;
        push(0, 32'hF0F, 4'd12);
        settle();
        check("flush_valid_1", cdb_valid_1, 1'b0);
        check("flush_valid_2", cdb_valid_2, 1'b0);
        advance();
        set_idle();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("post_flush_valid_1", cdb_valid_1, 1'b0);
            check("post_flush_full",    {full_alu_1, full_alu_2, full_lsb}, 3'b000);
            advance();
        end

        // Randomized traffic; producers mostly respect full.
        for (int i = 0; i < 4000; i++) begin
            logic [2:0] fl;
            fl  = {full_lsb, full_alu_2, full_alu_1};
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 39) == 0);
            for (int s = 0; s < 3; s++) begin
                done[s] = ($urandom_range(0, 99) < 60);
                if (fl[s] && $urandom_range(0, 15) != 0) done[s] = 1'b0;
                val[s] = $urandom;
                tag[s] = RW'($urandom);
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
